dma_controller: RTL
===================

Name: dma_controller

Overview:
- External-device DMA engine sitting beside cpu at the top level; the cpu's DMA interface (dma_begin, dma_command_addr, dma_bus_request, dma_bus_grant, dma_end) connects directly to it.
- On a device interrupt it asks the cpu for a destination address and requests the data bus.
- It then writes TOTAL_WORDS from the device into data memory, one LINE_SIZE line per bus tenure (cycle stealing), and signals completion.

Parameters:
- WORD_SIZE, 16, address/word width (from opcodes.v)
- LINE_SIZE, 64, memory line width in bits (from opcodes.v)
- LINE_WORDS, 4, words per line (LINE_SIZE/WORD_SIZE)
- TOTAL_WORDS, 12, words per transfer; must be a multiple of LINE_WORDS
- WRITE_LATENCY, 4, cycles d_writeM must be held per line write (≥1)

Ports:
- Clk  input  1  system clock, all state changes on posedge
- Reset_N  input  1  asynchronous active-low reset
- device_irq  input  1  level/pulse: device has TOTAL_WORDS ready
- dev_data  input  LINE_SIZE  device line selected by dev_line_idx (combinational from device)
- dev_line_idx  output  2  index of line currently being transferred
- dma_begin  output  1  one-cycle pulse to cpu requesting a command
- dma_command_addr  input  WORD_SIZE  destination base address from cpu
- dma_bus_request  output  1  request ownership of data bus
- dma_bus_grant  input  1  cpu has released the data bus
- dma_end  output  1  one-cycle pulse, transfer complete
- d_writeM  output  1  memory write strobe; high-Z unless in WRITE
- d_address  output  WORD_SIZE  memory address; high-Z unless in WRITE
- d_data  inout  LINE_SIZE  memory data; driven only in WRITE, else high-Z

Behaviour:
- Reset (async, Reset_N=0): state=IDLE, line counter=0, pending=0, base=0. dma_begin=0, dma_bus_request=0, dma_end=0. d_writeM/d_address/d_data immediately high-Z. dev_line_idx=0.
- States:
  - IDLE: if device_irq or pending → BEGIN, clear pending.
  - BEGIN: dma_begin=1 for exactly 1 cycle → CMD.
  - CMD: 1 cycle; at its closing edge latch base<=dma_command_addr, line=0 → REQ.
  - REQ: dma_bus_request=1; wait for dma_bus_grant=1 sampled high → WRITE, wait counter=0.
  - WRITE: dma_bus_request stays 1. Drive d_address=base+line*LINE_WORDS (16-bit modulo, wraps at 0xFFFF), d_data=dev_data, d_writeM=1. Hold WRITE_LATENCY cycles, then → RELEASE.
  - RELEASE: bus outputs high-Z, dma_bus_request=0 for 1 cycle (cpu may resume). If line==TOTAL_WORDS/LINE_WORDS-1 → DONE, else line+1 → REQ.
  - DONE: dma_end=1 for exactly 1 cycle → IDLE.
- Latency, no stalls, grant in the cycle after request:
  - irq→dma_begin: 1 cycle.
  - Per line: 1 REQ + WRITE_LATENCY + 1 RELEASE.
  - 12-word default: 1+1+3*(1+4+1)+1 = 21 cycles from BEGIN to end of DONE.
- Grant withdrawn mid-WRITE (dma_bus_grant=0): float the bus the same cycle, → REQ, retry the same line with the full WRITE_LATENCY restart. No partial write counts.
- device_irq while not IDLE: set pending. Multiple irqs collapse to one. Serviced after DONE.
- Grant asserted while not requesting: ignored.
- dma_command_addr sampled only in CMD; later changes are ignored.
- Never drive the bus without grant. dma_bus_request falls only in RELEASE, on abort→REQ (held), or on reset.

Decomposition:
- Shared package/header: state encodings (DMA_IDLE, DMA_BEGIN, DMA_CMD, DMA_REQ, DMA_WRITE, DMA_RELEASE, DMA_DONE), and LINE_WORDS and TOTAL_WORDS defaults next to WORD_SIZE/LINE_SIZE in opcodes.v.
- One natural sub-module, dma_bus_driver: tri-state drivers for d_writeM/d_address/d_data gated by an own_bus enable. Keeps high-Z logic out of the FSM.

Test Plan:
- Basic transfer: irq pulse, cpu returns addr 0x01F4, grant one cycle after request. Expect:
  - writes at 0x01F4, 0x01F8, 0x01FC, each with d_writeM high for 4 cycles;
  - dev_line_idx 0,1,2;
  - dma_end pulse at cycle 21 after dma_begin;
  - bus high-Z between lines.
- Delayed grant: grant held low 10 cycles in the second REQ. Expect request held steady, no bus drive, then normal completion; total grows by 10.
- Mid-write abort: drop grant in the 2nd WRITE cycle of line 1. Expect bus high-Z the same cycle; line 1 rewritten at 0x01F8 with a full 4-cycle strobe; 3 successful line writes total.
- Address wrap: base 0xFFFC. Expect addresses 0xFFFC, 0x0000, 0x0004.
- Pending irq: second irq during line 0. Expect a second dma_begin exactly 1 cycle after the first dma_end's IDLE cycle; a third irq during the same window is not duplicated.
- Async reset in WRITE: Reset_N low mid-strobe. Expect immediate high-Z bus and dma_bus_request=0 without a clock edge; after release, IDLE with no spurious dma_end.

Source files
------------

// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA controller slice.
// - Default widths and transfer geometry (word/line sizes, words per transfer,
//   write strobe length).
// - FSM state encoding used by the controller.
// - A helper that sizes counters so that a count of 1 still gets one bit.
package dma_controller_pkg;

  localparam int DMA_WORD_SIZE     = 16;
  localparam int DMA_LINE_SIZE     = 64;
  localparam int DMA_LINE_WORDS    = DMA_LINE_SIZE / DMA_WORD_SIZE;
  localparam int DMA_TOTAL_WORDS   = 12;
  localparam int DMA_WRITE_LATENCY = 4;
  localparam int DMA_LINE_IDX_W    = 2;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_BEGIN,
    DMA_CMD,
    DMA_REQ,
    DMA_WRITE,
    DMA_RELEASE,
    DMA_DONE
  } dma_state_t;

  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_controller_if.sv
// Handshake between the cpu and the DMA controller.
// - dma_begin        : DMA -> cpu, one-cycle request for a command
// - dma_command_addr : cpu -> DMA, destination base address
// - dma_bus_request  : DMA -> cpu, request ownership of the data bus
// - dma_bus_grant    : cpu -> DMA, data bus released to the DMA
// - dma_end          : DMA -> cpu, one-cycle transfer-complete pulse
// modport master is the DMA side, modport slave is the cpu side.
interface dma_controller_if
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE = DMA_WORD_SIZE
);

  logic                 dma_begin;
  logic [WORD_SIZE-1:0] dma_command_addr;
  logic                 dma_bus_request;
  logic                 dma_bus_grant;
  logic                 dma_end;

  modport master (
    output dma_begin,
    output dma_bus_request,
    output dma_end,
    input  dma_command_addr,
    input  dma_bus_grant
  );

  modport slave (
    input  dma_begin,
    input  dma_bus_request,
    input  dma_end,
    output dma_command_addr,
    output dma_bus_grant
  );

endinterface

// File: rtl/dma_controller_bus_driver.sv
// dma_bus_driver: tri-state drivers for the shared data-memory bus.
// - drive_en  : drive the bus this cycle (ownership already qualified by grant)
// - address   : line address to present on d_address
// - data      : line data to present on d_data
// - d_writeM / d_address / d_data : bus pins, high-Z whenever drive_en is low
module dma_bus_driver
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE = DMA_WORD_SIZE,
  parameter int LINE_SIZE = DMA_LINE_SIZE
) (
  input  logic                 drive_en,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [LINE_SIZE-1:0] data,
  output wire                  d_writeM,
  output wire  [WORD_SIZE-1:0] d_address,
  inout  wire  [LINE_SIZE-1:0] d_data
);

  assign d_writeM  = drive_en ? 1'b1 : 1'bz;
  assign d_address = drive_en ? address : {WORD_SIZE{1'bz}};
  assign d_data    = drive_en ? data : {LINE_SIZE{1'bz}};

endmodule

// File: rtl/dma_controller.sv
// dma_controller: cycle-stealing DMA engine between an external device and
// data memory. On a device interrupt it asks the cpu for a destination
// address, then writes TOTAL_WORDS from the device one line per bus tenure.
// Ports:
// - Clk, Reset_N     : clock, asynchronous active-low reset
// - device_irq       : device has a full transfer ready
// - dev_data         : device line selected by dev_line_idx
// - dev_line_idx     : index of the line being transferred
// - dma              : cpu handshake (dma_controller_if.master)
// - d_writeM, d_address, d_data : data-memory bus, high-Z unless writing
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE     = DMA_WORD_SIZE,
  parameter int LINE_SIZE     = DMA_LINE_SIZE,
  parameter int TOTAL_WORDS   = DMA_TOTAL_WORDS,
  parameter int WRITE_LATENCY = DMA_WRITE_LATENCY
) (
  input  logic                      Clk,
  input  logic                      Reset_N,
  input  logic                      device_irq,
  input  logic [LINE_SIZE-1:0]      dev_data,
  output logic [DMA_LINE_IDX_W-1:0] dev_line_idx,
  dma_controller_if.master          dma,
  output wire                       d_writeM,
  output wire  [WORD_SIZE-1:0]      d_address,
  inout  wire  [LINE_SIZE-1:0]      d_data
);

  localparam int LINE_WORDS  = LINE_SIZE / WORD_SIZE;
  localparam int TOTAL_LINES = TOTAL_WORDS / LINE_WORDS;
  localparam int WAIT_W      = counter_width(WRITE_LATENCY);

  localparam logic [DMA_LINE_IDX_W-1:0] LAST_LINE = DMA_LINE_IDX_W'(TOTAL_LINES - 1);
  localparam logic [WAIT_W-1:0]         LAST_WAIT = WAIT_W'(WRITE_LATENCY - 1);

  dma_state_t                state;
  logic [DMA_LINE_IDX_W-1:0] line;
  logic [WAIT_W-1:0]         wait_cnt;
  logic                      pending;
  logic [WORD_SIZE-1:0]      base;
  logic                      own_bus;
  logic                      begin_q;
  logic                      request_q;
  logic                      end_q;

  logic                      drive_en;
  logic [WORD_SIZE-1:0]      line_addr;

  // Address arithmetic is deliberately WORD_SIZE wide so a base near the top
  // of memory wraps around to 0 instead of growing a carry bit.
  assign line_addr = base + WORD_SIZE'(line) * WORD_SIZE'(LINE_WORDS);

  // own_bus is registered, but ownership also requires the grant right now:
  // a grant withdrawn mid-write floats the bus in the same cycle.
  assign drive_en = own_bus & dma.dma_bus_grant;

  assign dev_line_idx        = line;
  assign dma.dma_begin       = begin_q;
  assign dma.dma_bus_request = request_q;
  assign dma.dma_end         = end_q;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // branch reads the pre-edge values; blocking here would create ordering
  // dependencies between statements and mismatch simulation vs. synthesis.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state     <= DMA_IDLE;
      line      <= '0;
      wait_cnt  <= '0;
      pending   <= 1'b0;
      base      <= '0;
      own_bus   <= 1'b0;
      begin_q   <= 1'b0;
      request_q <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      // Interrupts arriving mid-transfer collapse into a single pending flag.
      if (state != DMA_IDLE && device_irq) begin
        pending <= 1'b1;
      end

      case (state)
        DMA_IDLE: begin
          if (device_irq || pending) begin
            pending <= 1'b0;
            begin_q <= 1'b1;
            state   <= DMA_BEGIN;
          end
        end

        DMA_BEGIN: begin
          begin_q <= 1'b0;
          state   <= DMA_CMD;
        end

        DMA_CMD: begin
          base      <= dma.dma_command_addr;
          line      <= '0;
          request_q <= 1'b1;
          state     <= DMA_REQ;
        end

        DMA_REQ: begin
          if (dma.dma_bus_grant) begin
            wait_cnt <= '0;
            own_bus  <= 1'b1;
            state    <= DMA_WRITE;
          end
        end

        DMA_WRITE: begin
          if (!dma.dma_bus_grant) begin
            // Aborted tenure: keep requesting and redo the whole line.
            wait_cnt <= '0;
            own_bus  <= 1'b0;
            state    <= DMA_REQ;
          end else if (wait_cnt == LAST_WAIT) begin
            own_bus   <= 1'b0;
            request_q <= 1'b0;
            state     <= DMA_RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DMA_RELEASE: begin
          if (line == LAST_LINE) begin
            end_q <= 1'b1;
            state <= DMA_DONE;
          end else begin
            line      <= line + 1'b1;
            request_q <= 1'b1;
            state     <= DMA_REQ;
          end
        end

        DMA_DONE: begin
          end_q <= 1'b0;
          state <= DMA_IDLE;
        end

        default: begin
          own_bus   <= 1'b0;
          begin_q   <= 1'b0;
          request_q <= 1'b0;
          end_q     <= 1'b0;
          state     <= DMA_IDLE;
        end
      endcase
    end
  end

  dma_bus_driver #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_SIZE (LINE_SIZE)
  ) u_bus_driver (
    .drive_en  (drive_en),
    .address   (line_addr),
    .data      (dev_data),
    .d_writeM  (d_writeM),
    .d_address (d_address),
    .d_data    (d_data)
  );

endmodule
